// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multi-cycle PC sequencer: FSM states, instruction
// kinds and PC-select codes.
package pc_seq_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_BR     = 3'd5;
   localparam logic [2:0] ST_JMP    = 3'd6;
   localparam logic [2:0] ST_HLT    = 3'd7;

   localparam logic [2:0] KIND_ALU    = 3'b000;
   localparam logic [2:0] KIND_LOAD   = 3'b001;
   localparam logic [2:0] KIND_STORE  = 3'b010;
   localparam logic [2:0] KIND_BRANCH = 3'b011;
   localparam logic [2:0] KIND_JUMP   = 3'b100;
   localparam logic [2:0] KIND_HALT   = 3'b101;

   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_JMP = 2'b10;

   // Codes 110 and 111 are the only unassigned instruction kinds.
   function automatic logic kind_is_illegal(input logic [2:0] kind);
      return kind[2] & kind[1];
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between the sequencer (master) and the decode/memory/PC
// datapath (slave).
interface pc_sequencer_if #(parameter int CNT_W = 32);

   logic [2:0]       InstrKind;
   logic             BranchTaken;
   logic             MemReady;
   logic [1:0]       PCSel;
   logic             PCWrite;
   logic             IRWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             RegWrite;
   logic             Halted;
   logic             Fault;
   logic [CNT_W-1:0] CycleCnt;
   logic [CNT_W-1:0] RetireCnt;

   modport master (
      input  InstrKind, BranchTaken, MemReady,
      output PCSel, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
             Halted, Fault, CycleCnt, RetireCnt
   );

   modport slave (
      output InstrKind, BranchTaken, MemReady,
      input  PCSel, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
             Halted, Fault, CycleCnt, RetireCnt
   );

endinterface

// File: rtl/mc_perf_counter.sv
// Cycle and retired-instruction counters; both wrap silently at 2^CNT_W.
module mc_perf_counter #(parameter int CNT_W = 32) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             cyc_en,
   input  logic             ret_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cycle_r;
   logic [CNT_W-1:0] retire_r;

   // Counter registers with independent enables
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cycle_r  <= CNT_ZERO;
         retire_r <= CNT_ZERO;
      end else begin
         if (cyc_en) begin
            cycle_r <= cycle_r + CNT_ONE;
         end
         if (ret_en) begin
            retire_r <= retire_r + CNT_ONE;
         end
      end
   end

   assign cycle_cnt  = cycle_r;
   assign retire_cnt = retire_r;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: steps each instruction through fetch/decode/exec/
// mem/writeback and drives PC-select, write strobes and memory requests.
module pc_sequencer
   import pc_seq_pkg::*;
#(parameter int CNT_W = 32) (
   input  logic            Clk,
   input  logic            Rst,
   pc_sequencer_if.master  bus
);

   logic [2:0] state_r;
   logic [2:0] state_nxt_s;
   logic [2:0] kind_r;
   logic       fault_r;
   logic       retire_s;

   // State, latched instruction kind and sticky fault flag
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= ST_FETCH;
         kind_r  <= KIND_ALU;
         fault_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_DECODE) begin
            kind_r  <= bus.InstrKind;
            fault_r <= fault_r | kind_is_illegal(bus.InstrKind);
         end else begin
            kind_r  <= kind_r;
            fault_r <= fault_r;
         end
      end
   end

   // Next-state selection and retire strobe
   always_comb begin
      state_nxt_s = state_r;
      retire_s    = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (bus.MemReady) state_nxt_s = ST_DECODE;
            else              state_nxt_s = ST_FETCH;
         end
         ST_DECODE: begin
            case (bus.InstrKind)
               KIND_ALU, KIND_LOAD, KIND_STORE: state_nxt_s = ST_EXEC;
               KIND_BRANCH:                     state_nxt_s = ST_BR;
               KIND_JUMP:                       state_nxt_s = ST_JMP;
               KIND_HALT: begin
                  state_nxt_s = ST_HLT;
                  retire_s    = 1'b1;
               end
               default:                         state_nxt_s = ST_HLT;
            endcase
         end
         ST_EXEC: begin
            if (kind_r == KIND_ALU) state_nxt_s = ST_WB;
            else                    state_nxt_s = ST_MEM;
         end
         ST_MEM: begin
            if (!bus.MemReady) begin
               state_nxt_s = ST_MEM;
            end else if (kind_r == KIND_LOAD) begin
               state_nxt_s = ST_WB;
            end else begin
               state_nxt_s = ST_FETCH;
               retire_s    = 1'b1;
            end
         end
         ST_WB, ST_BR, ST_JMP: begin
            state_nxt_s = ST_FETCH;
            retire_s    = 1'b1;
         end
         ST_HLT:  state_nxt_s = ST_HLT;
         default: state_nxt_s = ST_FETCH;
      endcase
   end

   // Moore outputs, plus the MemReady/BranchTaken-qualified strobes
   always_comb begin
      bus.PCSel    = PCSEL_SEQ;
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      case (state_r)
         ST_FETCH: begin
            bus.MemRead = 1'b1;
            bus.IRWrite = bus.MemReady;
            bus.PCWrite = bus.MemReady;
         end
         ST_MEM: begin
            bus.MemRead  = (kind_r == KIND_LOAD);
            bus.MemWrite = (kind_r == KIND_STORE);
         end
         ST_WB:   bus.RegWrite = 1'b1;
         ST_BR: begin
            bus.PCSel   = PCSEL_BR;
            bus.PCWrite = bus.BranchTaken;
         end
         ST_JMP: begin
            bus.PCSel   = PCSEL_JMP;
            bus.PCWrite = 1'b1;
         end
         default: bus.PCSel = PCSEL_SEQ;
      endcase
   end

   assign bus.Halted = (state_r == ST_HLT);
   assign bus.Fault  = fault_r;

   mc_perf_counter #(.CNT_W(CNT_W)) u_perf (
      .Clk        (Clk),
      .Rst        (Rst),
      .cyc_en     (state_r != ST_HLT),
      .ret_en     (retire_s),
      .cycle_cnt  (bus.CycleCnt),
      .retire_cnt (bus.RetireCnt)
   );

endmodule
